// File: rtl/contrast_brightness_pipe.sv
// contrast_brightness_pipe
//   Pipelined per-channel contrast/brightness stage for the colour-reduction
//   video path:  out = sat(((in - MID) * gain >>> GAIN_FRAC) + MID + offset)
//
//   Ports
//     clk, reset        rising-edge clock, synchronous active-high reset
//     in_valid/in_sof   input pixel qualifier and start-of-frame (sof only
//                       meaningful with in_valid)
//     in_rgb            NUM_CH channels of CH_W bits, channel 0 in the LSBs
//     cfg_load          pulse: capture cfg_gain/cfg_offset into shadow regs
//     cfg_gain          unsigned gain, GAIN_FRAC fractional bits
//     cfg_offset        signed brightness offset, CH_W+1 bits
//     out_valid/out_sof/out_rgb  adjusted pixel, 4 register stages after input
//     frame_clips       clipped-pixel count of the last completed frame
//     clips_valid       one-cycle pulse when frame_clips updates
//
//   Handshake: no backpressure. A pixel is accepted on every rising edge where
//   in_valid=1; it is presented on out_rgb with out_valid=1 after the third
//   following edge (sampled at edge N, visible after edge N+3). Bubbles
//   travel through as out_valid=0 and out_rgb holds its last value.
module contrast_brightness_pipe #(
  parameter int CH_W      = 8,
  parameter int NUM_CH    = 3,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 4,
  parameter int CNT_W     = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [NUM_CH*CH_W-1:0]   in_rgb,
  input  logic                     cfg_load,
  input  logic [GAIN_W-1:0]        cfg_gain,
  input  logic [CH_W:0]            cfg_offset,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic [NUM_CH*CH_W-1:0]   out_rgb,
  output logic [CNT_W-1:0]         frame_clips,
  output logic                     clips_valid
);

  localparam int PW   = CH_W + GAIN_W + 2;  // full-precision product width
  localparam int QW   = PW + 2;             // guard bits for + MID + offset
  localparam int MID  = 2 ** (CH_W - 1);
  localparam int MAXV = 2 ** CH_W - 1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1 << GAIN_FRAC);

  // Config: shadow written by cfg_load, active copied from shadow on sof
  logic [GAIN_W-1:0]   shadow_gain, act_gain, pix_gain;
  logic signed [CH_W:0] shadow_offset, act_offset, pix_offset;
  logic                take_sof;

  assign take_sof = in_valid & in_sof;

  // The sof pixel itself already uses the freshly activated config.
  always_comb begin
    pix_gain   = take_sof ? shadow_gain   : act_gain;
    pix_offset = take_sof ? shadow_offset : act_offset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_gain   <= GAIN_ONE;
      shadow_offset <= '0;
      act_gain      <= GAIN_ONE;
      act_offset    <= '0;
    end else begin
      // Shadow update lands after this edge, so a same-cycle sof copies the
      // old shadow value.
      if (cfg_load) begin
        shadow_gain   <= cfg_gain;
        shadow_offset <= $signed(cfg_offset);
      end
      if (take_sof) begin
        act_gain   <= shadow_gain;
        act_offset <= shadow_offset;
      end
    end
  end

  // S1: centre around MID. Gain/offset ride along with the pixel.
  logic                 s1_valid, s1_sof;
  logic signed [CH_W:0] s1_d [NUM_CH];
  logic [GAIN_W-1:0]    s1_gain;
  logic signed [CH_W:0] s1_offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_gain   <= '0;
      s1_offset <= '0;
      for (int c = 0; c < NUM_CH; c++) s1_d[c] <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_sof    <= take_sof;
      s1_gain   <= pix_gain;
      s1_offset <= pix_offset;
      for (int c = 0; c < NUM_CH; c++)
        s1_d[c] <= $signed({1'b0, in_rgb[c*CH_W +: CH_W]} - (CH_W+1)'(MID));
    end
  end

  // S2: full-precision signed product
  logic                 s2_valid, s2_sof;
  logic signed [PW-1:0] s2_p [NUM_CH];
  logic signed [CH_W:0] s2_offset;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_offset <= '0;
      for (int c = 0; c < NUM_CH; c++) s2_p[c] <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_sof    <= s1_sof;
      s2_offset <= s1_offset;
      for (int c = 0; c < NUM_CH; c++)
        s2_p[c] <= PW'(s1_d[c]) * PW'($signed({1'b0, s1_gain}));
    end
  end

  // S3: rescale (>>> floors toward -inf) and re-bias in a guarded width
  logic                 s3_valid, s3_sof;
  logic signed [QW-1:0] s3_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s3_sof   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) s3_q[c] <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_sof   <= s2_sof;
      for (int c = 0; c < NUM_CH; c++)
        s3_q[c] <= (QW'(s2_p[c]) >>> GAIN_FRAC) + QW'(MID) + QW'(s2_offset);
    end
  end

  // Saturation and clip detection feeding the output register
  logic [NUM_CH*CH_W-1:0] sat_rgb;
  logic                   any_clip;

  always_comb begin
    sat_rgb  = '0;
    any_clip = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (s3_q[c] < 0) begin
        sat_rgb[c*CH_W +: CH_W] = '0;
        any_clip = 1'b1;
      end else if (s3_q[c] > QW'(MAXV)) begin
        sat_rgb[c*CH_W +: CH_W] = '1;
        any_clip = 1'b1;
      end else begin
        sat_rgb[c*CH_W +: CH_W] = s3_q[c][CH_W-1:0];
      end
    end
  end

  // Output register and per-frame clip statistic
  logic [CNT_W-1:0] run_clips;
  logic             seen_sof;  // clips before the first sof are not reported

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_rgb     <= '0;
      frame_clips <= '0;
      clips_valid <= 1'b0;
      run_clips   <= '0;
      seen_sof    <= 1'b0;
    end else begin
      out_valid   <= s3_valid;
      out_sof     <= s3_valid & s3_sof;
      clips_valid <= 1'b0;
      if (s3_valid) begin
        out_rgb <= sat_rgb;
        if (s3_sof) begin
          frame_clips <= seen_sof ? run_clips : '0;
          clips_valid <= 1'b1;
          seen_sof    <= 1'b1;
          run_clips   <= CNT_W'(any_clip);
        end else if (any_clip && run_clips != '1) begin
          run_clips <= run_clips + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_contrast_brightness_pipe.sv
// tb_contrast_brightness_pipe
//   Table of directed pixels/config events plus a random phase and a reset
//   sequence. Expected pixels and frame clip counts are queued when driven and
//   compared when the DUT presents them.
module tb_contrast_brightness_pipe;

  localparam int CNT_W = 20;
  localparam int EW    = 16 + 1 + 24;  // {due cycle, sof, rgb}

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_sof, cfg_load;
  logic [23:0]       in_rgb;
  logic [7:0]        cfg_gain;
  logic [8:0]        cfg_offset;
  logic              out_valid, out_sof, clips_valid;
  logic [23:0]       out_rgb;
  logic [CNT_W-1:0]  frame_clips;

  contrast_brightness_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sof(in_sof), .in_rgb(in_rgb),
    .cfg_load(cfg_load), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
    .out_valid(out_valid), .out_sof(out_sof), .out_rgb(out_rgb),
    .frame_clips(frame_clips), .clips_valid(clips_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] clip_q[$];

  // reference state
  logic [7:0] sh_g, ac_g;
  logic [8:0] sh_o, ac_o;
  int         run;
  logic       seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pk(input int c0, input int c1, input int c2);
    logic [7:0] a, b, d;
    a = 8'(c0); b = 8'(c1); d = 8'(c2);
    return {d, b, a};
  endfunction

  // returns {clipped, rgb}
  function automatic logic [24:0] model(input logic [23:0] rgb, input logic [7:0] g,
                                        input logic [8:0] o);
    logic [23:0] r;
    logic        cl;
    int          d, p, q;
    r  = '0;
    cl = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d = int'(rgb[c*8 +: 8]) - 128;
      p = d * int'(g);
      q = (p >>> 4) + 128 + int'($signed(o));
      if (q < 0) begin r[c*8 +: 8] = 8'd0; cl = 1'b1; end
      else if (q > 255) begin r[c*8 +: 8] = 8'd255; cl = 1'b1; end
      else r[c*8 +: 8] = 8'(q);
    end
    return {cl, r};
  endfunction

  task automatic model_reset();
    sh_g = 8'h10; ac_g = 8'h10; sh_o = '0; ac_o = '0;
    run = 0; seen = 1'b0;
    exp_q.delete();
    clip_q.delete();
  endtask

  // driver: one cycle of stimulus; use_exp selects the table value over the model
  task automatic step(input logic v, input logic sof, input logic [23:0] rgb,
                      input logic ld, input logic [7:0] g, input logic [8:0] o,
                      input logic use_exp, input logic [23:0] texp);
    logic [24:0] m;
    @(negedge clk);
    in_valid = v; in_sof = sof; in_rgb = rgb;
    cfg_load = ld; cfg_gain = g; cfg_offset = o;
    if (v) begin
      if (sof) begin ac_g = sh_g; ac_o = sh_o; end
      m = model(rgb, ac_g, ac_o);
      exp_q.push_back({16'(cyc + 4), sof, use_exp ? texp : m[23:0]});
      if (sof) begin
        clip_q.push_back(seen ? CNT_W'(run) : '0);
        seen = 1'b1;
        run  = m[24] ? 1 : 0;
      end else if (m[24]) begin
        run++;
      end
    end
    if (ld) begin sh_g = g; sh_o = o; end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0, 0, '0);
  endtask

  // scoreboard
  always @(posedge clk) begin
    logic [EW-1:0] e;
    logic          exp_cv;
    cyc = cyc + 1;
    #1;
    exp_cv = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("latency", 32'(cyc), 32'(e[40:25]));
        chk("out_rgb", 32'(out_rgb), 32'(e[23:0]));
        chk("out_sof", 32'(out_sof), 32'(e[24]));
        exp_cv = e[24];
      end
    end else if (exp_q.size() != 0 && int'(exp_q[0][40:25]) <= cyc) begin
      e = exp_q.pop_front();
      chk("missing_pixel", 32'(out_valid), 32'd1);
    end
    chk("clips_valid", 32'(clips_valid), 32'(exp_cv));
    if (exp_cv && clips_valid) begin
      if (clip_q.size() == 0) chk("clip_q_empty", 32'd0, 32'd1);
      else chk("frame_clips", 32'(frame_clips), 32'(clip_q.pop_front()));
    end
  end

  typedef struct {
    logic        v, sof, ld;
    logic [7:0]  g;
    logic [8:0]  o;
    logic [23:0] rgb, exp;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic sof, input logic ld,
                              input logic [7:0] g, input logic [8:0] o,
                              input logic [23:0] rgb, input logic [23:0] exp);
    vec_t t;
    t.v = v; t.sof = sof; t.ld = ld; t.g = g; t.o = o; t.rgb = rgb; t.exp = exp;
    return t;
  endfunction

  vec_t tbl[18];

  initial begin
    // unity gain pass-through
    tbl[0]  = mk(1, 1, 0, 8'h00, 9'h000, pk(192,192,192), pk(192,192,192));
    // gain 2.0, clipping frame with a bubble inside
    tbl[1]  = mk(0, 0, 1, 8'h20, 9'h000, '0, '0);
    tbl[2]  = mk(1, 1, 0, 8'h00, 9'h000, pk(47,192,84),  pk(0,255,40));
    tbl[3]  = mk(1, 0, 0, 8'h00, 9'h000, pk(47,83,192),  pk(0,38,255));
    tbl[4]  = mk(0, 0, 0, 8'h00, 9'h000, '0, '0);
    tbl[5]  = mk(1, 0, 0, 8'h00, 9'h000, pk(47,192,84),  pk(0,255,40));
    // brightness: +20, -256, +255
    tbl[6]  = mk(0, 0, 1, 8'h10, 9'd20,  '0, '0);
    tbl[7]  = mk(1, 1, 0, 8'h00, 9'h000, pk(47,192,84),  pk(67,212,104));
    tbl[8]  = mk(0, 0, 1, 8'h10, 9'h100, '0, '0);
    tbl[9]  = mk(1, 1, 0, 8'h00, 9'h000, pk(47,192,84),  pk(0,0,0));
    tbl[10] = mk(0, 0, 1, 8'h10, 9'h0ff, '0, '0);
    tbl[11] = mk(1, 1, 0, 8'h00, 9'h000, pk(47,192,84),  pk(255,255,255));
    // mid-frame load does not apply until the next sof
    tbl[12] = mk(1, 0, 1, 8'h20, 9'h000, pk(47,192,84),  pk(255,255,255));
    tbl[13] = mk(1, 0, 0, 8'h00, 9'h000, pk(100,100,100), pk(255,255,255));
    // load with sof: the sof pixel takes the earlier shadow (gain 2.0)
    tbl[14] = mk(1, 1, 1, 8'h10, 9'h000, pk(47,83,192),  pk(0,38,255));
    tbl[15] = mk(1, 0, 0, 8'h00, 9'h000, pk(47,83,192),  pk(0,38,255));
    tbl[16] = mk(1, 1, 0, 8'h00, 9'h000, pk(200,10,128), pk(200,10,128));
    tbl[17] = mk(0, 0, 0, 8'h00, 9'h000, '0, '0);

    reset = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_rgb = '0;
    cfg_load = 1'b0; cfg_gain = '0; cfg_offset = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_sof", 32'(out_sof), 32'd0);
    chk("reset_out_rgb", 32'(out_rgb), 32'd0);
    chk("reset_frame_clips", 32'(frame_clips), 32'd0);
    chk("reset_clips_valid", 32'(clips_valid), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++)
      step(tbl[i].v, tbl[i].sof, tbl[i].rgb, tbl[i].ld, tbl[i].g, tbl[i].o, 1'b1, tbl[i].exp);
    bubbles(6);

    // random frames with random config loads and valid gaps
    for (int i = 0; i < 200; i++) begin
      logic v, s, l;
      v = ($urandom_range(0, 3) != 0);
      s = v && ($urandom_range(0, 11) == 0);
      l = ($urandom_range(0, 9) == 0);
      step(v, s, 24'($urandom), l, 8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)),
           1'b0, '0);
    end
    bubbles(6);

    // reset with three pixels in flight under gain 2.0
    step(0, 0, '0, 1, 8'h20, 9'h000, 0, '0);
    step(1, 1, pk(47,192,84), 0, 8'h00, 9'h000, 1, pk(0,255,40));
    bubbles(4);
    step(1, 0, pk(47,192,84), 0, 8'h00, 9'h000, 0, '0);
    step(1, 0, pk(47,83,192), 0, 8'h00, 9'h000, 0, '0);
    step(1, 0, pk(100,20,30), 0, 8'h00, 9'h000, 0, '0);
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; cfg_load = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_frame_clips", 32'(frame_clips), 32'd0);
    reset = 1'b0;
    bubbles(6);
    // non-sof pixel uses the active config, which must be back at 1.0
    step(1, 0, pk(47,192,84), 0, 8'h00, 9'h000, 1, pk(47,192,84));
    bubbles(6);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("clip_q_drained", 32'(clip_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
